// File: rtl/sdram_write_arbiter_pkg.sv
// Shared constants for the SDRAM write path: boolean aliases, bus widths
// common to terminal_stream, this arbiter and the SDRAM controller, and the
// write-request record carried through the arbiter.
package sdram_write_arbiter_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = 4;
  localparam int BURST_W = 9;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [MASK_W-1:0]  mask;
    logic [BURST_W-1:0] burst;
  } wr_req_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  // Idle value of the controller-facing fields: all bytes enabled, single beat.
  localparam wr_req_t WR_REQ_IDLE = '{
    addr:  {ADDR_W{1'b0}},
    data:  {DATA_W{1'b0}},
    mask:  {MASK_W{1'b1}},
    burst: BURST_W'(1)
  };

endpackage

// File: rtl/sdram_write_arbiter_write_request_slot.sv
// One-deep capture slot for a write master. A request pulse is latched only
// when the slot is empty and the port has no transaction in flight; extra
// pulses are dropped and the captured fields stay put. The arbiter empties
// the slot with clear_i on the cycle it grants this port.
module write_request_slot
  import sdram_write_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    req_i,
  input  wr_req_t fields_i,
  input  logic    in_flight_i,
  input  logic    clear_i,
  output logic    pending_o,
  output wr_req_t fields_o
);

  logic    pending_q, pending_d;
  wr_req_t fields_q, fields_d;
  logic    capture;

  assign capture = req_i && !pending_q && !in_flight_i;

  // Capture takes priority; clear only ever arrives while pending, so they never collide.
  always_comb begin
    pending_d = pending_q;
    fields_d  = fields_q;
    if (capture) begin
      pending_d = TRUE;
      fields_d  = fields_i;
    end else if (clear_i) begin
      pending_d = FALSE;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= FALSE;
      fields_q  <= '0;
    end else begin
      pending_q <= pending_d;
      fields_q  <= fields_d;
    end
  end

  assign pending_o = pending_q;
  assign fields_o  = fields_q;

endmodule

// File: rtl/sdram_write_arbiter.sv
// Round-robin arbiter sharing the single SDRAM write port between master A
// (terminal stream) and master B (secondary loader). One transaction is
// forwarded at a time; wr_done is routed back to the owning master.
//
// state | meaning
// IDLE  | no transaction; grant a pending slot if any
// ISSUE | fields loaded, wr_request pulse registered on the way out
// WAIT  | waiting for the (registered) wr_done from the controller
module sdram_write_arbiter
  import sdram_write_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               a_wr_request,
  input  logic [ADDR_W-1:0]  a_wr_address,
  input  logic [DATA_W-1:0]  a_wr_data,
  input  logic [MASK_W-1:0]  a_wr_mask,
  input  logic [BURST_W-1:0] a_wr_burst_length,
  output logic               a_wr_done,
  output logic               a_busy,
  input  logic               b_wr_request,
  input  logic [ADDR_W-1:0]  b_wr_address,
  input  logic [DATA_W-1:0]  b_wr_data,
  input  logic [MASK_W-1:0]  b_wr_mask,
  input  logic [BURST_W-1:0] b_wr_burst_length,
  output logic               b_wr_done,
  output logic               b_busy,
  output logic [ADDR_W-1:0]  wr_address,
  output logic [DATA_W-1:0]  wr_data,
  output logic [MASK_W-1:0]  wr_mask,
  output logic [BURST_W-1:0] wr_burst_length,
  output logic               wr_request,
  input  logic               wr_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0] state_q, state_d;
  port_t      owner_q, owner_d;     // doubles as last_grant
  wr_req_t    out_q, out_d;
  logic       wr_request_q, wr_request_d;
  logic       wr_done_q, wr_done_d;
  logic       a_done_q, a_done_d;
  logic       b_done_q, b_done_d;

  wr_req_t    a_in, b_in, a_fields, b_fields;
  logic       a_pending, b_pending;
  logic       a_in_flight, b_in_flight;
  logic       a_clear, b_clear;
  logic       grant_b;

  assign a_in = '{addr: a_wr_address, data: a_wr_data, mask: a_wr_mask, burst: a_wr_burst_length};
  assign b_in = '{addr: b_wr_address, data: b_wr_data, mask: b_wr_mask, burst: b_wr_burst_length};

  assign a_in_flight = (state_q != ST_IDLE) && (owner_q == PORT_A);
  assign b_in_flight = (state_q != ST_IDLE) && (owner_q == PORT_B);

  write_request_slot u_slot_a (
    .clk         (clk),
    .reset       (reset),
    .req_i       (a_wr_request),
    .fields_i    (a_in),
    .in_flight_i (a_in_flight),
    .clear_i     (a_clear),
    .pending_o   (a_pending),
    .fields_o    (a_fields)
  );

  write_request_slot u_slot_b (
    .clk         (clk),
    .reset       (reset),
    .req_i       (b_wr_request),
    .fields_i    (b_in),
    .in_flight_i (b_in_flight),
    .clear_i     (b_clear),
    .pending_o   (b_pending),
    .fields_o    (b_fields)
  );

  // B wins when it is the only one pending, or on a tie when A was granted last.
  assign grant_b = b_pending && (!a_pending || (owner_q == PORT_A));

  // A done pulse seen outside WAIT is dropped here so it can never complete a later transaction.
  assign wr_done_d = wr_done && (state_q == ST_WAIT);

  // Grant, issue and completion sequencing.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    out_d        = out_q;
    wr_request_d = FALSE;
    a_done_d     = FALSE;
    b_done_d     = FALSE;
    a_clear      = FALSE;
    b_clear      = FALSE;
    case (state_q)
      ST_IDLE: begin
        if (a_pending || b_pending) begin
          if (grant_b) begin
            owner_d = PORT_B;
            out_d   = b_fields;
            b_clear = TRUE;
          end else begin
            owner_d = PORT_A;
            out_d   = a_fields;
            a_clear = TRUE;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wr_request_d = TRUE;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (wr_done_q) begin
          a_done_d = (owner_q == PORT_A);
          b_done_d = (owner_q == PORT_B);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_B;
      out_q        <= WR_REQ_IDLE;
      wr_request_q <= FALSE;
      wr_done_q    <= FALSE;
      a_done_q     <= FALSE;
      b_done_q     <= FALSE;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      out_q        <= out_d;
      wr_request_q <= wr_request_d;
      wr_done_q    <= wr_done_d;
      a_done_q     <= a_done_d;
      b_done_q     <= b_done_d;
    end
  end

  assign wr_address      = out_q.addr;
  assign wr_data         = out_q.data;
  assign wr_mask         = out_q.mask;
  assign wr_burst_length = out_q.burst;
  assign wr_request      = wr_request_q;
  assign a_wr_done       = a_done_q;
  assign b_wr_done       = b_done_q;
  assign a_busy          = a_pending || a_in_flight;
  assign b_busy          = b_pending || b_in_flight;

endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Self-checking bench for sdram_write_arbiter: reset values, a per-cycle
// vector table for the round-robin tie case, hand-written multi-cycle
// sequences, and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_sdram_write_arbiter;
  import sdram_write_arbiter_pkg::*;

  logic               clk;
  logic               reset;
  logic               a_wr_request, b_wr_request;
  logic [ADDR_W-1:0]  a_wr_address, b_wr_address;
  logic [DATA_W-1:0]  a_wr_data, b_wr_data;
  logic [MASK_W-1:0]  a_wr_mask, b_wr_mask;
  logic [BURST_W-1:0] a_wr_burst_length, b_wr_burst_length;
  logic               a_wr_done, b_wr_done, a_busy, b_busy;
  logic [ADDR_W-1:0]  wr_address;
  logic [DATA_W-1:0]  wr_data;
  logic [MASK_W-1:0]  wr_mask;
  logic [BURST_W-1:0] wr_burst_length;
  logic               wr_request;
  logic               wr_done;

  sdram_write_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .a_wr_request      (a_wr_request),
    .a_wr_address      (a_wr_address),
    .a_wr_data         (a_wr_data),
    .a_wr_mask         (a_wr_mask),
    .a_wr_burst_length (a_wr_burst_length),
    .a_wr_done         (a_wr_done),
    .a_busy            (a_busy),
    .b_wr_request      (b_wr_request),
    .b_wr_address      (b_wr_address),
    .b_wr_data         (b_wr_data),
    .b_wr_mask         (b_wr_mask),
    .b_wr_burst_length (b_wr_burst_length),
    .b_wr_done         (b_wr_done),
    .b_busy            (b_busy),
    .wr_address        (wr_address),
    .wr_data           (wr_data),
    .wr_mask           (wr_mask),
    .wr_burst_length   (wr_burst_length),
    .wr_request        (wr_request),
    .wr_done           (wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic a_req, b_req, done;
    logic exp_req, exp_ad, exp_bd, exp_ab, exp_bb;
    int   src;   // 0: don't check fields, 1: A's fields, 2: B's fields
  } vec_t;
  vec_t tbl[18];

  wr_req_t rst_f, fa, fb, fx;
  int      pulses, reqs;

  // random-run model state
  bit      outst[2], unserved[2];
  int      acc[2];
  wr_req_t slot[2];
  int      last, cur, ed_cyc, ed_port, sd_cnt, grants, g, p;
  bit      sd_busy, c0, c1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_fields(input string name, input wr_req_t e);
    chk({name, ".addr"},  64'(wr_address),      64'(e.addr));
    chk({name, ".data"},  64'(wr_data),         64'(e.data));
    chk({name, ".mask"},  64'(wr_mask),         64'(e.mask));
    chk({name, ".burst"}, 64'(wr_burst_length), 64'(e.burst));
  endtask

  task automatic drive_port(input int pp, input logic req, input wr_req_t f);
    if (pp == 0) begin
      a_wr_request = req; a_wr_address = f.addr; a_wr_data = f.data;
      a_wr_mask = f.mask; a_wr_burst_length = f.burst;
    end else begin
      b_wr_request = req; b_wr_address = f.addr; b_wr_data = f.data;
      b_wr_mask = f.mask; b_wr_burst_length = f.burst;
    end
  endtask

  function automatic wr_req_t rand_req();
    wr_req_t r;
    r.addr  = 23'($urandom) & 23'h7FFFFC;
    r.data  = $urandom;
    r.mask  = 4'($urandom);
    r.burst = 9'($urandom_range(0, 256));
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    a_wr_request = 1'b0; b_wr_request = 1'b0; wr_done = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".wr_request"}, 64'(wr_request), 0);
    chk_fields(name, rst_f);
    chk({name, ".a_done"}, 64'(a_wr_done), 0);
    chk({name, ".b_done"}, 64'(b_wr_done), 0);
    chk({name, ".a_busy"}, 64'(a_busy), 0);
    chk({name, ".b_busy"}, 64'(b_busy), 0);
  endtask

  initial begin
    rst_f = '{addr: 23'h0, data: 32'h0, mask: 4'hF, burst: 9'd1};
    fx    = '{addr: 23'h0, data: 32'h0, mask: 4'h0, burst: 9'd0};
    drive_port(0, 1'b0, fx);
    drive_port(1, 1'b0, fx);
    wr_done = 1'b0;

    // ---- reset values
    reset = 1'b1;
    step();
    step();
    chk_reset_vals("reset");
    reset = 1'b0;

    // ---- single A write
    fa = '{addr: 23'h000104, data: 32'hDEADBEEF, mask: 4'hF, burst: 9'd1};
    drive_port(0, 1'b1, fa);
    step();
    a_wr_request = 1'b0;
    chk("single.a_busy_pending", 64'(a_busy), 1);
    chk("single.req_n", 64'(wr_request), 0);
    step();
    chk("single.req_n1", 64'(wr_request), 0);
    step();
    chk("single.req_n2", 64'(wr_request), 1);
    chk_fields("single", fa);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single.req_low", 64'(wr_request), 0);
      chk("single.no_early_done", 64'(a_wr_done), 0);
    end
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    chk("single.done_m", 64'(a_wr_done), 0);
    step();
    chk("single.a_done", 64'(a_wr_done), 1);
    chk("single.b_done", 64'(b_wr_done), 0);
    step();
    chk("single.a_done_1cyc", 64'(a_wr_done), 0);
    chk("single.a_busy_end", 64'(a_busy), 0);

    // ---- vector table: simultaneous requests, two rounds of tie-break
    do_reset();
    fa = '{addr: 23'h000200, data: 32'hA5A5A5A5, mask: 4'h3, burst: 9'd8};
    fb = '{addr: 23'h1F0000, data: 32'h5A5A5A5A, mask: 4'hC, burst: 9'd0};
    drive_port(0, 1'b0, fa);
    drive_port(1, 1'b0, fb);
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 1, 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[2]  = '{0, 0, 0, 1, 0, 0, 1, 1, 1};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 1, 1, 1};
    tbl[4]  = '{0, 0, 0, 0, 1, 0, 0, 1, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 2};
    tbl[6]  = '{0, 0, 0, 1, 0, 0, 0, 1, 2};
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 0, 1, 2};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, 0, 2};
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 1, 1, 2};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    tbl[11] = '{0, 0, 0, 1, 0, 0, 1, 1, 1};
    tbl[12] = '{0, 0, 1, 0, 0, 0, 1, 1, 1};
    tbl[13] = '{0, 0, 0, 0, 1, 0, 0, 1, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 2};
    tbl[15] = '{0, 0, 0, 1, 0, 0, 0, 1, 2};
    tbl[16] = '{0, 0, 1, 0, 0, 0, 0, 1, 2};
    tbl[17] = '{0, 0, 0, 0, 0, 1, 0, 0, 2};
    for (int i = 0; i < 18; i++) begin
      a_wr_request = tbl[i].a_req;
      b_wr_request = tbl[i].b_req;
      wr_done      = tbl[i].done;
      step();
      chk($sformatf("tbl%0d.wr_request", i), 64'(wr_request), 64'(tbl[i].exp_req));
      chk($sformatf("tbl%0d.a_done", i),     64'(a_wr_done),  64'(tbl[i].exp_ad));
      chk($sformatf("tbl%0d.b_done", i),     64'(b_wr_done),  64'(tbl[i].exp_bd));
      chk($sformatf("tbl%0d.a_busy", i),     64'(a_busy),     64'(tbl[i].exp_ab));
      chk($sformatf("tbl%0d.b_busy", i),     64'(b_busy),     64'(tbl[i].exp_bb));
      if (tbl[i].src == 1) chk_fields($sformatf("tbl%0d.A", i), fa);
      if (tbl[i].src == 2) chk_fields($sformatf("tbl%0d.B", i), fb);
    end
    a_wr_request = 1'b0; b_wr_request = 1'b0; wr_done = 1'b0;

    // ---- B arrives during A's long WAIT
    do_reset();
    fa = '{addr: 23'h000400, data: 32'hCAFEF00D, mask: 4'hF, burst: 9'd32};
    fb = '{addr: 23'h000800, data: 32'h0BADC0DE, mask: 4'h5, burst: 9'd4};
    drive_port(0, 1'b1, fa);
    step();
    a_wr_request = 1'b0;
    step();
    step();
    chk("hold.a_issue", 64'(wr_request), 1);
    chk_fields("hold.a_issue", fa);
    for (int i = 0; i < 40; i++) begin
      if (i == 3) drive_port(1, 1'b1, fb);
      else b_wr_request = 1'b0;
      if (i == 4) b_wr_data = 32'hFFFF0000;
      step();
      chk("hold.req_low", 64'(wr_request), 0);
      chk("hold.a_busy", 64'(a_busy), 1);
      chk_fields("hold.a_fields", fa);
      if (i >= 3) chk("hold.b_busy", 64'(b_busy), 1);
    end
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    step();
    chk("hold.a_done", 64'(a_wr_done), 1);
    chk("hold.b_still_busy", 64'(b_busy), 1);
    step();
    chk("hold.b_grant_edge", 64'(wr_request), 0);
    step();
    chk("hold.b_issue", 64'(wr_request), 1);
    chk_fields("hold.b_issue", fb);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    step();
    chk("hold.b_done", 64'(b_wr_done), 1);
    chk("hold.a_done_quiet", 64'(a_wr_done), 0);

    // ---- duplicate A pulse while pending is ignored
    fa = '{addr: 23'h000010, data: 32'hDA7A0001, mask: 4'hF, burst: 9'd2};
    drive_port(0, 1'b1, fa);
    step();
    a_wr_data = 32'h11111111;
    step();
    a_wr_request = 1'b0;
    step();
    chk("dup.issue", 64'(wr_request), 1);
    chk_fields("dup", fa);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    pulses = 0;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_wr_done) pulses++;
      if (wr_request) reqs++;
    end
    chk("dup.done_count", 64'(pulses), 1);
    chk("dup.no_second_issue", 64'(reqs), 0);

    // ---- reset while in WAIT
    fa = '{addr: 23'h00ABC0, data: 32'h12345678, mask: 4'h9, burst: 9'd16};
    drive_port(0, 1'b1, fa);
    step();
    a_wr_request = 1'b0;
    step();
    step();
    chk("rst_wait.issue", 64'(wr_request), 1);
    step();
    wr_done = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    wr_done = 1'b0;
    chk_reset_vals("rst_wait");
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (a_wr_done || b_wr_done) pulses++;
    end
    chk("rst_wait.no_done", 64'(pulses), 0);
    fa = '{addr: 23'h000100, data: 32'h87654321, mask: 4'h6, burst: 9'd256};
    drive_port(0, 1'b1, fa);
    step();
    a_wr_request = 1'b0;
    step();
    step();
    chk("rst_wait.new_issue", 64'(wr_request), 1);
    chk_fields("rst_wait.new", fa);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    step();
    chk("rst_wait.new_done", 64'(a_wr_done), 1);

    // ---- stray wr_done while IDLE
    step();
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    pulses = 0;
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_wr_done || b_wr_done || a_busy || b_busy) pulses++;
      if (wr_request) reqs++;
    end
    chk("stray.no_effect", 64'(pulses), 0);
    chk("stray.no_req", 64'(reqs), 0);
    fb = '{addr: 23'h000FF0, data: 32'h00C0FFEE, mask: 4'hA, burst: 9'd3};
    drive_port(1, 1'b1, fb);
    step();
    b_wr_request = 1'b0;
    step();
    step();
    chk("stray.b_issue_latency", 64'(wr_request), 1);
    chk_fields("stray.b", fb);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    step();
    chk("stray.b_done", 64'(b_wr_done), 1);

    // ---- randomized run against a transaction-level model
    do_reset();
    last = 1; cur = 0; ed_cyc = -10; ed_port = 0; sd_busy = 0; sd_cnt = 0; grants = 0;
    for (int k = 0; k < 2; k++) begin
      outst[k] = 0; unserved[k] = 0; acc[k] = 0; slot[k] = fx;
    end
    for (int c = 1; c <= 4000; c++) begin
      step();
      if (wr_request) begin
        g  = c - 1;
        c0 = unserved[0] && (acc[0] <= g - 1);
        c1 = unserved[1] && (acc[1] <= g - 1);
        chk("rnd.issue_while_busy", 64'(sd_busy), 0);
        if (!c0 && !c1) begin
          n_cmp++;
          n_err++;
          $display("FAIL rnd.grant: wr_request=1 at cycle %0d, expected 0 (nothing pending)", c);
        end else begin
          p = (c0 && c1) ? (1 - last) : (c0 ? 0 : 1);
          chk_fields(p == 0 ? "rnd.A" : "rnd.B", slot[p]);
          unserved[p] = 0;
          last = p;
          cur = p;
          sd_busy = 1;
          sd_cnt = $urandom_range(1, 8);
          grants++;
        end
      end
      chk("rnd.a_done", 64'(a_wr_done), 64'(ed_cyc == c && ed_port == 0));
      chk("rnd.b_done", 64'(b_wr_done), 64'(ed_cyc == c && ed_port == 1));
      if (ed_cyc == c) outst[ed_port] = 0;

      if (sd_busy) begin
        sd_cnt--;
        if (sd_cnt == 0) begin
          wr_done = 1'b1;
          sd_busy = 0;
          ed_cyc = c + 2;
          ed_port = cur;
        end else begin
          wr_done = 1'b0;
        end
      end else begin
        wr_done = (c >= ed_cyc) && ($urandom_range(0, 15) == 0);
      end

      for (int k = 0; k < 2; k++) begin
        if (outst[k]) begin
          drive_port(k, ($urandom_range(0, 7) == 0), rand_req());
        end else if (c <= 3700 && $urandom_range(0, 3) == 0) begin
          slot[k] = rand_req();
          drive_port(k, 1'b1, slot[k]);
          outst[k] = 1;
          unserved[k] = 1;
          acc[k] = c + 1;
        end else begin
          drive_port(k, 1'b0, rand_req());
        end
      end
    end
    a_wr_request = 1'b0; b_wr_request = 1'b0; wr_done = 1'b0;
    chk("rnd.drained", {62'd0, outst[1], outst[0]}, 0);
    chk("rnd.enough_grants", 64'(grants >= 50), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
